elevator_scan_ctrl: RTL and testbench

Parametrised elevator car controller, the next generation of our 5-floor one-hot elevator block. It generalises the floor count and the step timing. Unlike the previous block, it latches every hall/car call in a pending register and serves calls in SCAN order: it keeps its direction while calls remain ahead, then reverses. It also runs a timed door-open phase at each served floor. It sits between the debounced call buttons and the floor/status display logic.

---
 rtl/elevator_scan_ctrl.sv | 177 +++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scan_ctrl.sv
// rtl/elevator_scan_ctrl.sv - SCAN-order elevator car controller with latched calls and timed door
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   call_req      per-floor call request pulses, OR-latched into pending
//   pending       latched calls not yet served
//   current_floor one-hot car position (bit 0 = bottom floor)
//   floor_idx     binary index of current_floor
//   dir_up        1 = travelling/pointing up, 0 = down
//   moving        car is travelling between floors
//   door_open     door phase in progress
//   stop          car stationary (idle or door open)
module elevator_scan_ctrl #(
    parameter int FLOORS     = 5,
    parameter int TICK_DIV   = 100000000,
    parameter int DOOR_TICKS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FLOORS-1:0]         call_req,
    output logic [FLOORS-1:0]         pending,
    output logic [FLOORS-1:0]         current_floor,
    output logic [$clog2(FLOORS)-1:0] floor_idx,
    output logic                      dir_up,
    output logic                      moving,
    output logic                      door_open,
    output logic                      stop
);

    localparam int FIDX_W = $clog2(FLOORS);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DOOR_W = $clog2(DOOR_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    state_t              state;
    logic [TICK_W-1:0]   tick_cnt;
    logic [DOOR_W-1:0]   door_cnt;
    logic                tick;

    logic                above_any;
    logic                below_any;
    logic                here;
    logic                ahead;
    logic                behind;
    logic                door_hit;

    state_t              state_nxt;
    logic                dir_nxt;
    logic [FLOORS-1:0]   floor_nxt;
    logic [FIDX_W-1:0]   idx_nxt;
    logic [DOOR_W-1:0]   door_nxt;
    logic [FLOORS-1:0]   clear_mask;
    logic [FLOORS-1:0]   req_eff;
    logic [FLOORS-1:0]   pending_nxt;

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    // Pending calls split by side of the car; "ahead" follows the current heading.
    always_comb begin
        above_any = 1'b0;
        below_any = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (FIDX_W'(i) > floor_idx) above_any = above_any | pending[i];
            if (FIDX_W'(i) < floor_idx) below_any = below_any | pending[i];
        end
    end

    assign here     = |(pending & current_floor);
    assign ahead    = dir_up ? above_any : below_any;
    assign behind   = dir_up ? below_any : above_any;
    // A call at the floor whose door is open just holds the door instead of latching.
    assign door_hit = (state == S_DOOR) && (|(call_req & current_floor));

    always_comb begin
        state_nxt  = state;
        dir_nxt    = dir_up;
        floor_nxt  = current_floor;
        idx_nxt    = floor_idx;
        door_nxt   = door_cnt;
        clear_mask = '0;

        // Door reload overrides both the per-tick decrement and the exit decision.
        if (door_hit) door_nxt = DOOR_W'(DOOR_TICKS);

        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (here) begin
                        state_nxt  = S_DOOR;
                        door_nxt   = DOOR_W'(DOOR_TICKS);
                        clear_mask = current_floor;
                    end else if (above_any) begin
                        dir_nxt   = 1'b1;
                        state_nxt = S_MOVE;
                    end else if (below_any) begin
                        dir_nxt   = 1'b0;
                        state_nxt = S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (here) begin
                        state_nxt  = S_DOOR;
                        door_nxt   = DOOR_W'(DOOR_TICKS);
                        clear_mask = current_floor;
                    end else if (ahead) begin
                        if (dir_up && floor_idx != FIDX_W'(FLOORS - 1)) begin
                            floor_nxt = current_floor << 1;
                            idx_nxt   = floor_idx + FIDX_W'(1);
                        end else if (!dir_up && floor_idx != '0) begin
                            floor_nxt = current_floor >> 1;
                            idx_nxt   = floor_idx - FIDX_W'(1);
                        end
                    end else if (behind) begin
                        dir_nxt = ~dir_up;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                S_DOOR: begin
                    if (!door_hit) begin
                        // <= 1 also recovers from a zero count should one ever appear.
                        if (door_cnt <= DOOR_W'(1)) begin
                            door_nxt = '0;
                            if (ahead) begin
                                state_nxt = S_MOVE;
                            end else if (behind) begin
                                dir_nxt   = ~dir_up;
                                state_nxt = S_MOVE;
                            end else begin
                                state_nxt = S_IDLE;
                            end
                        end else begin
                            door_nxt = door_cnt - DOOR_W'(1);
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign req_eff     = call_req & ~((state == S_DOOR) ? current_floor : '0);
    assign pending_nxt = (pending | req_eff) & ~clear_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            tick_cnt      <= '0;
            door_cnt      <= '0;
            pending       <= '0;
            current_floor <= FLOORS'(1);
            floor_idx     <= '0;
            dir_up        <= 1'b1;
            moving        <= 1'b0;
            door_open     <= 1'b0;
            stop          <= 1'b1;
        end else begin
            tick_cnt      <= tick ? '0 : tick_cnt + TICK_W'(1);
            state         <= state_nxt;
            door_cnt      <= door_nxt;
            pending       <= pending_nxt;
            current_floor <= floor_nxt;
            floor_idx     <= idx_nxt;
            dir_up        <= dir_nxt;
            moving        <= (state_nxt == S_MOVE);
            door_open     <= (state_nxt == S_DOOR);
            stop          <= (state_nxt != S_MOVE);
        end
    end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb/tb_elevator_scan_ctrl.sv - directed self-checking bench for elevator_scan_ctrl
module tb_elevator_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] call_req = '0;
    logic [4:0] pending;
    logic [4:0] current_floor;
    logic [2:0] floor_idx;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic       stop;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    elevator_scan_ctrl #(
        .FLOORS(5),
        .TICK_DIV(4),
        .DOOR_TICKS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .call_req(call_req),
        .pending(pending),
        .current_floor(current_floor),
        .floor_idx(floor_idx),
        .dir_up(dir_up),
        .moving(moving),
        .door_open(door_open),
        .stop(stop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic to_tick(input int k);
        while (cyc < 4 * k) clk1();
    endtask

    task automatic pulse(input logic [4:0] v);
        call_req = v;
        clk1();
        call_req = '0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        call_req = '0;
        clk1();
        clk1();
        clk1();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_cf"},    32'(current_floor), 32'h01);
        check({pfx, "_idx"},   32'(floor_idx),     32'h0);
        check({pfx, "_pend"},  32'(pending),       32'h0);
        check({pfx, "_stop"},  32'(stop),          32'h1);
        check({pfx, "_door"},  32'(door_open),     32'h0);
        check({pfx, "_dir"},   32'(dir_up),        32'h1);
        check({pfx, "_move"},  32'(moving),        32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then reset in the middle of a move, then tick counter restart
        do_reset();
        check_reset_vals("rst");
        pulse(5'h10);
        to_tick(3);
        check("mid_cf",   32'(current_floor), 32'h04);
        check("mid_move", 32'(moving),        32'h1);
        rst = 1'b1;
        clk1();
        check_reset_vals("rst2");
        clk1();
        clk1();
        rst = 1'b0;
        cyc = 0;
        pulse(5'h02);
        while (cyc < 3) clk1();
        check("pretick_move", 32'(moving), 32'h0);
        to_tick(1);
        check("tick1_move", 32'(moving), 32'h1);

        // Single call to floor 3
        do_reset();
        pulse(5'h08);
        check("s_pend", 32'(pending), 32'h08);
        to_tick(1);
        check("s_t1_move", 32'(moving),        32'h1);
        check("s_t1_cf",   32'(current_floor), 32'h01);
        to_tick(2);
        check("s_t2_cf",   32'(current_floor), 32'h02);
        check("s_t2_idx",  32'(floor_idx),     32'h1);
        to_tick(3);
        check("s_t3_cf",   32'(current_floor), 32'h04);
        to_tick(4);
        check("s_t4_cf",   32'(current_floor), 32'h08);
        check("s_t4_idx",  32'(floor_idx),     32'h3);
        to_tick(5);
        check("s_t5_door", 32'(door_open),     32'h1);
        check("s_t5_pend", 32'(pending),       32'h0);
        check("s_t5_cf",   32'(current_floor), 32'h08);
        to_tick(6);
        check("s_t6_door", 32'(door_open),     32'h1);
        to_tick(7);
        check("s_t7_stop", 32'(stop),          32'h1);
        check("s_t7_door", 32'(door_open),     32'h0);
        check("s_t7_move", 32'(moving),        32'h0);

        // Door extend by a call at the open floor
        do_reset();
        pulse(5'h08);
        to_tick(6);
        check("x_t6_door", 32'(door_open), 32'h1);
        pulse(5'h08);
        check("x_pend",    32'(pending),   32'h0);
        to_tick(7);
        check("x_t7_door", 32'(door_open), 32'h1);
        to_tick(8);
        check("x_t8_door", 32'(door_open), 32'h0);
        check("x_t8_stop", 32'(stop),      32'h1);
        check("x_t8_pend", 32'(pending),   32'h0);

        // Call at the current floor while idle
        do_reset();
        pulse(5'h01);
        check("h_pend",    32'(pending),       32'h01);
        to_tick(1);
        check("h_t1_door", 32'(door_open),     32'h1);
        check("h_t1_cf",   32'(current_floor), 32'h01);
        check("h_t1_pend", 32'(pending),       32'h0);
        check("h_t1_move", 32'(moving),        32'h0);
        to_tick(2);
        check("h_t2_door", 32'(door_open),     32'h1);
        to_tick(3);
        check("h_t3_door", 32'(door_open),     32'h0);
        check("h_t3_stop", 32'(stop),          32'h1);

        // SCAN order: keep going up to floor 4, then come back for floor 1
        do_reset();
        pulse(5'h10);
        to_tick(3);
        check("c_t3_cf",   32'(current_floor), 32'h04);
        pulse(5'h02);
        check("c_pend",    32'(pending),       32'h12);
        to_tick(4);
        check("c_t4_cf",   32'(current_floor), 32'h08);
        to_tick(5);
        check("c_t5_cf",   32'(current_floor), 32'h10);
        to_tick(6);
        check("c_t6_door", 32'(door_open),     32'h1);
        check("c_t6_pend", 32'(pending),       32'h02);
        to_tick(8);
        check("c_t8_move", 32'(moving),        32'h1);
        check("c_t8_dir",  32'(dir_up),        32'h0);
        check("c_t8_cf",   32'(current_floor), 32'h10);
        to_tick(9);
        check("c_t9_cf",   32'(current_floor), 32'h08);
        to_tick(10);
        check("c_t10_cf",  32'(current_floor), 32'h04);
        to_tick(11);
        check("c_t11_cf",  32'(current_floor), 32'h02);
        to_tick(12);
        check("c_t12_door", 32'(door_open),    32'h1);
        check("c_t12_pend", 32'(pending),      32'h0);
        check("c_t12_cf",  32'(current_floor), 32'h02);
        to_tick(14);
        check("c_t14_stop", 32'(stop),         32'h1);
        check("c_t14_dir", 32'(dir_up),        32'h0);

        // Top floor boundary: turn around without shifting, walk down to floor 0
        do_reset();
        pulse(5'h10);
        to_tick(5);
        check("b_t5_cf",   32'(current_floor), 32'h10);
        check("b_t5_idx",  32'(floor_idx),     32'h4);
        to_tick(8);
        check("b_t8_stop", 32'(stop),          32'h1);
        check("b_t8_dir",  32'(dir_up),        32'h1);
        check("b_t8_cf",   32'(current_floor), 32'h10);
        pulse(5'h01);
        to_tick(9);
        check("b_t9_dir",  32'(dir_up),        32'h0);
        check("b_t9_move", 32'(moving),        32'h1);
        check("b_t9_cf",   32'(current_floor), 32'h10);
        check("b_t9_idx",  32'(floor_idx),     32'h4);
        to_tick(10);
        check("b_t10_idx", 32'(floor_idx),     32'h3);
        to_tick(11);
        check("b_t11_idx", 32'(floor_idx),     32'h2);
        to_tick(12);
        check("b_t12_idx", 32'(floor_idx),     32'h1);
        to_tick(13);
        check("b_t13_idx", 32'(floor_idx),     32'h0);
        check("b_t13_cf",  32'(current_floor), 32'h01);
        to_tick(14);
        check("b_t14_door", 32'(door_open),    32'h1);
        check("b_t14_pend", 32'(pending),      32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
